// File: rtl/wbm_single_pkg.sv
// Shared constants and state type for the single-transaction Wishbone initiator.
package wbm_single_pkg;

    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/wbm_single_if.sv
// Command/response and Wishbone master signals of wbm_single; master = the initiator,
// slave = the requester plus the bus interconnect it talks to.
interface wbm_single_if
    import wbm_single_pkg::*;
#(
    parameter int AW = 30
);
    logic             i_cmd_stb;
    logic             i_cmd_we;
    logic [AW-1:0]    i_cmd_addr;
    logic [WB_DW-1:0] i_cmd_data;
    logic [WB_SW-1:0] i_cmd_sel;
    logic             i_abort;
    logic             o_cmd_busy;
    logic             o_rsp_stb;
    logic             o_rsp_err;
    logic [WB_DW-1:0] o_rsp_data;

    logic             o_wb_cyc;
    logic             o_wb_stb;
    logic             o_wb_we;
    logic [AW-1:0]    o_wb_addr;
    logic [WB_DW-1:0] o_wb_data;
    logic [WB_SW-1:0] o_wb_sel;
    logic             i_wb_stall;
    logic             i_wb_ack;
    logic             i_wb_err;
    logic [WB_DW-1:0] i_wb_data;

    modport master (
        input  i_cmd_stb, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel, i_abort,
        output o_cmd_busy, o_rsp_stb, o_rsp_err, o_rsp_data,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    modport slave (
        output i_cmd_stb, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel, i_abort,
        input  o_cmd_busy, o_rsp_stb, o_rsp_err, o_rsp_data,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

endinterface

// File: rtl/wbm_timeout.sv
// Saturating bus-cycle timer; o_expired flags the cycle whose increment reaches all-ones,
// so an enabled run of 2^LG-1 cycles ends on the last of them.
module wbm_timeout #(
    parameter int LG = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [LG-1:0] LAST = LG'((64'd1 << LG) - 64'd2);

    logic [LG-1:0] count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && (count != '1)) begin
            count <= count + LG'(1);
        end
    end

    assign o_expired = i_enable && (count >= LAST);

endmodule

// File: rtl/wbm_single.sv
// Single-transaction pipelined Wishbone initiator: one command in, one bus transfer,
// one response (data, bus error or timeout) out.
module wbm_single
    import wbm_single_pkg::*;
#(
    parameter int AW         = 30,
    parameter int TIMEOUT_LG = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    wbm_single_if.master bus
);

    state_t           state;
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [AW-1:0]    wb_addr;
    logic [WB_DW-1:0] wb_data;
    logic [WB_SW-1:0] wb_sel;
    logic             cmd_busy;
    logic             rsp_stb;
    logic             rsp_err;
    logic [WB_DW-1:0] rsp_data;
    logic             expired;
    logic             bus_done;

    wbm_timeout #(
        .LG(TIMEOUT_LG)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (state == IDLE),
        .i_enable (wb_cyc),
        .o_expired(expired)
    );

    // ack/err only count once the strobe has been taken, or while waiting for it
    assign bus_done = (bus.i_wb_ack || bus.i_wb_err)
                   && (((state == REQ) && !bus.i_wb_stall) || (state == WAIT));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_sel   <= '0;
            cmd_busy <= 1'b0;
            rsp_stb  <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_cmd_stb) begin
                        state    <= REQ;
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        cmd_busy <= 1'b1;
                        wb_we    <= bus.i_cmd_we;
                        wb_addr  <= bus.i_cmd_addr;
                        wb_data  <= bus.i_cmd_data;
                        wb_sel   <= bus.i_cmd_sel;
                    end
                end
                REQ, WAIT: begin
                    // Any ending returns to IDLE; completion beats abort, abort beats timeout.
                    if (bus_done || bus.i_abort || expired) begin
                        state    <= IDLE;
                        wb_cyc   <= 1'b0;
                        wb_stb   <= 1'b0;
                        cmd_busy <= 1'b0;
                    end
                    if (bus_done) begin
                        rsp_stb  <= 1'b1;
                        rsp_err  <= bus.i_wb_err;
                        rsp_data <= (bus.i_wb_err || wb_we) ? '0 : bus.i_wb_data;
                    end else if (!bus.i_abort && expired) begin
                        rsp_stb  <= 1'b1;
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end else if (!bus.i_abort && (state == REQ) && !bus.i_wb_stall) begin
                        wb_stb <= 1'b0;
                        state  <= WAIT;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wb_cyc   <= 1'b0;
                    wb_stb   <= 1'b0;
                    cmd_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_wb_cyc   = wb_cyc;
    assign bus.o_wb_stb   = wb_stb;
    assign bus.o_wb_we    = wb_we;
    assign bus.o_wb_addr  = wb_addr;
    assign bus.o_wb_data  = wb_data;
    assign bus.o_wb_sel   = wb_sel;
    assign bus.o_cmd_busy = cmd_busy;
    assign bus.o_rsp_stb  = rsp_stb;
    assign bus.o_rsp_err  = rsp_err;
    assign bus.o_rsp_data = rsp_data;

endmodule

// File: tb/tb_wbm_single.sv
// Bench for wbm_single: a reactive slave driven per cycle, checked against a
// transfer-level model of cycle counts, response timing and response contents.
module tb_wbm_single;

    localparam int TLG  = 4;
    localparam int TMAX = (1 << TLG) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int unsigned edge_count = 0;

    wbm_single_if #(.AW(30)) bus ();

    wbm_single #(
        .AW(30),
        .TIMEOUT_LG(TLG)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_count <= edge_count + 1;

    logic [103:0] outs;
    assign outs = {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_cmd_busy, bus.o_rsp_stb,
                   bus.o_rsp_err, bus.o_rsp_data, bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel};

    typedef struct packed {
        int          cyc_n;
        int          stb_n;
        int          rsp_n;
        int          rsp_k;
        logic        err;
        logic [31:0] data;
        logic        ok;
    } res_t;

    function automatic string fmt(input res_t r);
        return $sformatf("cyc=%0d stb=%0d rsp=%0d@%0d err=%0b data=%h ok=%0b",
                         r.cyc_n, r.stb_n, r.rsp_n, r.rsp_k, r.err, r.data, r.ok);
    endfunction

    // Transfer-level expectation: strobe taken after s stalls, ack d cycles later,
    // cut short by abort or by the 2^TLG-1 cycle timeout.
    function automatic res_t model(input bit we, input int s, input int d, input bit use_err,
                                   input logic [31:0] rdata, input int abort_at);
        res_t r;
        int   t;
        int   fin;
        r    = '0;
        r.ok = 1'b1;
        t    = s + 1 + d;
        fin  = (t <= TMAX) ? t : TMAX;
        if (abort_at > 0 && abort_at <= fin && abort_at != t) begin
            r.cyc_n = abort_at;
            r.stb_n = (s + 1 < abort_at) ? s + 1 : abort_at;
        end else begin
            r.cyc_n = fin;
            r.stb_n = (s + 1 < fin) ? s + 1 : fin;
            r.rsp_n = 1;
            r.rsp_k = fin + 1;
            r.err   = (t > TMAX) || use_err;
            r.data  = (r.err || we) ? 32'h0 : rdata;
        end
        return r;
    endfunction

    task automatic slave_idle();
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        bus.i_abort    = 1'b0;
    endtask

    // Issues one command in the current cycle (caller sits just after a rising edge)
    // and plays the slave until cyc drops; returns in the cycle cyc is first low.
    task automatic xfer(input bit we, input logic [29:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input int s, input int d, input bit use_err,
                        input logic [31:0] rdata, input int abort_at, output res_t r);
        int acc;
        bit done;
        r    = '0;
        r.ok = 1'b1;
        acc  = -1;
        done = 1'b0;
        bus.i_cmd_stb  = 1'b1;
        bus.i_cmd_we   = we;
        bus.i_cmd_addr = addr;
        bus.i_cmd_data = wdata;
        bus.i_cmd_sel  = sel;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk);
            #1;
            bus.i_cmd_stb  = 1'b0;
            bus.i_cmd_we   = 1'($urandom);
            bus.i_cmd_addr = 30'($urandom);
            bus.i_cmd_data = $urandom;
            bus.i_cmd_sel  = 4'($urandom);
            if (bus.o_rsp_stb === 1'b1) begin
                r.rsp_n++;
                r.rsp_k = k;
                r.err   = bus.o_rsp_err;
                r.data  = bus.o_rsp_data;
            end
            if (bus.o_cmd_busy !== bus.o_wb_cyc) r.ok = 1'b0;
            if (k == 1 && !(bus.o_wb_cyc === 1'b1 && bus.o_wb_stb === 1'b1)) r.ok = 1'b0;
            if (bus.o_wb_cyc === 1'b1) begin
                r.cyc_n++;
                if (bus.o_wb_we !== we || bus.o_wb_addr !== addr || bus.o_wb_data !== wdata
                    || bus.o_wb_sel !== sel) r.ok = 1'b0;
                bus.i_wb_stall = bus.o_wb_stb && (r.stb_n < s);
                if (bus.o_wb_stb === 1'b1) r.stb_n++;
                if (bus.o_wb_stb === 1'b1 && !bus.i_wb_stall && acc < 0) acc = k;
                if (acc >= 0 && k == acc + d) begin
                    bus.i_wb_ack  = 1'b1;
                    bus.i_wb_err  = use_err;
                    bus.i_wb_data = rdata;
                end else if (bus.i_wb_stall) begin
                    bus.i_wb_ack  = 1'($urandom);
                    bus.i_wb_err  = 1'($urandom);
                    bus.i_wb_data = $urandom;
                end else begin
                    bus.i_wb_ack  = 1'b0;
                    bus.i_wb_err  = 1'b0;
                    bus.i_wb_data = $urandom;
                end
                bus.i_abort = (k == abort_at);
            end else begin
                slave_idle();
                done = 1'b1;
            end
        end
        if (!done) begin
            slave_idle();
            r.rsp_k = -1;
        end
    endtask

    task automatic test_reset();
        bus.i_cmd_stb  = 1'b0;
        bus.i_cmd_we   = 1'b0;
        bus.i_cmd_addr = '0;
        bus.i_cmd_data = '0;
        bus.i_cmd_sel  = '0;
        bus.i_wb_data  = '0;
        slave_idle();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outs !== 104'd0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h want 0", outs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outs !== 104'd0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h want 0", outs);
        end
    endtask

    task automatic test_zero_wait_read();
        res_t r, e;
        xfer(1'b0, 30'h10, $urandom, 4'hF, 0, 1, 1'b0, 32'hDEADBEEF, 0, r);
        e = model(1'b0, 0, 1, 1'b0, 32'hDEADBEEF, 0);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL zero_wait_read: got %s want %s", fmt(r), fmt(e));
        end
    endtask

    task automatic test_stalled_write();
        res_t r, e;
        xfer(1'b1, 30'h20, 32'h0001_0001, 4'hF, 3, 2, 1'b0, 32'hCAFE_F00D, 0, r);
        e = model(1'b1, 3, 2, 1'b0, 32'hCAFE_F00D, 0);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL stalled_write: got %s want %s", fmt(r), fmt(e));
        end
    endtask

    task automatic test_bus_error();
        res_t r, e;
        int   s, d;
        for (int i = 0; i < 3; i++) begin
            s = i;
            d = 2 - i;
            xfer(1'b0, 30'($urandom), $urandom, 4'($urandom), s, d, 1'b1, 32'h1234_5678, 0, r);
            e = model(1'b0, s, d, 1'b1, 32'h1234_5678, 0);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL bus_error[%0d]: got %s want %s", i, fmt(r), fmt(e));
            end
        end
    endtask

    task automatic test_timeout();
        res_t r, e;
        int   sv[4] = '{0, 0, 0, 20};
        int   dv[4] = '{40, 14, 13, 0};
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 30'($urandom), $urandom, 4'hF, sv[i], dv[i], 1'b0, 32'hA5A5_0F0F, 0, r);
            e = model(1'b0, sv[i], dv[i], 1'b0, 32'hA5A5_0F0F, 0);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got %s want %s", i, fmt(r), fmt(e));
            end
        end
        xfer(1'b0, 30'h3, $urandom, 4'h3, 0, 1, 1'b0, 32'h0BAD_CAFE, 0, r);
        e = model(1'b0, 0, 1, 1'b0, 32'h0BAD_CAFE, 0);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL timeout_recover: got %s want %s", fmt(r), fmt(e));
        end
    endtask

    task automatic test_abort();
        res_t r, e;
        int   sv[3] = '{0, 4, 1};
        int   dv[3] = '{5, 3, 2};
        int   av[3] = '{3, 2, 4};
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 30'($urandom), $urandom, 4'hF, sv[i], dv[i], 1'b0, 32'h7777_1111, av[i], r);
            e = model(1'b0, sv[i], dv[i], 1'b0, 32'h7777_1111, av[i]);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL abort[%0d]: got %s want %s", i, fmt(r), fmt(e));
            end
        end
    endtask

    task automatic test_async_reset();
        res_t r, e;
        bus.i_cmd_stb  = 1'b1;
        bus.i_cmd_we   = 1'b1;
        bus.i_cmd_addr = 30'h155;
        bus.i_cmd_data = 32'hFFFF_0000;
        bus.i_cmd_sel  = 4'hC;
        bus.i_wb_stall = 1'b1;
        @(posedge clk);
        #1;
        bus.i_cmd_stb = 1'b0;
        checks++;
        if ({bus.o_wb_cyc, bus.o_wb_stb} !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_req: cyc/stb=%b want 11", {bus.o_wb_cyc, bus.o_wb_stb});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs !== 104'd0) begin
            errors++;
            $display("FAIL async_reset_mid: outputs=%h want 0", outs);
        end
        rst = 1'b0;
        bus.i_wb_stall = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_cmd_busy, bus.o_rsp_stb} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_idle: cyc/stb/busy/rsp=%b want 0000",
                     {bus.o_wb_cyc, bus.o_wb_stb, bus.o_cmd_busy, bus.o_rsp_stb});
        end
        xfer(1'b0, 30'h44, $urandom, 4'hF, 1, 1, 1'b0, 32'h5555_AAAA, 0, r);
        e = model(1'b0, 1, 1, 1'b0, 32'h5555_AAAA, 0);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL async_reset_recover: got %s want %s", fmt(r), fmt(e));
        end
    endtask

    task automatic test_back_to_back();
        res_t        r, e;
        logic [31:0] rd;
        int unsigned start;
        start = edge_count;
        for (int i = 0; i < 3; i++) begin
            rd = $urandom;
            xfer(1'b0, 30'(i + 1), $urandom, 4'hF, 0, 1, 1'b0, rd, 0, r);
            e = model(1'b0, 0, 1, 1'b0, rd, 0);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(r), fmt(e));
            end
        end
        checks++;
        if (edge_count - start != 9) begin
            errors++;
            $display("FAIL back_to_back_rate: %0d cycles for 3 transfers want 9", edge_count - start);
        end
    endtask

    task automatic test_random();
        res_t        r, e;
        bit          we, use_err;
        int          s, d, t, fin, ab;
        logic [31:0] rd;
        for (int i = 0; i < 30; i++) begin
            we      = 1'($urandom);
            s       = int'($urandom_range(0, 4));
            d       = int'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) d = int'($urandom_range(10, 20));
            use_err = ($urandom_range(0, 3) == 0);
            rd      = $urandom;
            t       = s + 1 + d;
            fin     = (t <= TMAX) ? t : TMAX;
            ab      = ($urandom_range(0, 6) == 0 && fin > 1) ? int'($urandom_range(1, fin - 1)) : 0;
            xfer(we, 30'($urandom), $urandom, 4'($urandom), s, d, use_err, rd, ab, r);
            e = model(we, s, d, use_err, rd, ab);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL random[%0d] we=%0b s=%0d d=%0d err=%0b ab=%0d: got %s want %s",
                         i, we, s, d, use_err, ab, fmt(r), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_stalled_write();
        test_bus_error();
        test_timeout();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
